// File: rtl/ucsbece154a_alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU op codes, FSM state
// encodings and a small op-code decode helper.
package ucsbece154a_alu_arb_pkg;

  // ALUcontrol op codes
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;
  localparam logic [2:0] ALUOP_SLT = 3'b101;

  // Arbiter FSM state encodings
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // True when the op code is one the ALU implements
  function automatic logic op_supported(input logic [2:0] op);
    logic ok;
    case (op)
      ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_SLT: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ucsbece154a_alu_arb_if.sv
// Operand/result bundle between the arbiter (master) and the shared ALU (slave).
interface ucsbece154a_alu_arb_if;

  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucontrol;
  logic [31:0] result;
  logic        zero;
  logic        err;

  modport master (output a, output b, output alucontrol,
                  input  result, input zero, input err);

  modport slave  (input  a, input b, input alucontrol,
                  output result, output zero, output err);

endinterface

// File: rtl/ucsbece154a_alu_arb_alu.sv
// Combinational 32-bit ALU. A single adder serves add, sub and slt; slt uses
// the subtract path plus operand signs so signed overflow is handled.
module ucsbece154a_alu
  import ucsbece154a_alu_arb_pkg::*;
(
  ucsbece154a_alu_arb_if.slave alu_bus
);

  logic        sub_s;
  logic [31:0] b_eff_s;
  logic [31:0] sum_s;
  logic        slt_s;
  logic [31:0] result_s;
  logic        err_s;

  // Shared adder and result select; unsupported codes yield zero with err set
  always_comb begin
    sub_s    = (alu_bus.alucontrol == ALUOP_SUB) || (alu_bus.alucontrol == ALUOP_SLT);
    b_eff_s  = sub_s ? ~alu_bus.b : alu_bus.b;
    sum_s    = alu_bus.a + b_eff_s + {31'd0, sub_s};
    slt_s    = (alu_bus.a[31] ^ alu_bus.b[31]) ? alu_bus.a[31] : sum_s[31];
    result_s = 32'd0;
    err_s    = 1'b0;
    case (alu_bus.alucontrol)
      ALUOP_ADD: result_s = sum_s;
      ALUOP_SUB: result_s = sum_s;
      ALUOP_AND: result_s = alu_bus.a & alu_bus.b;
      ALUOP_OR:  result_s = alu_bus.a | alu_bus.b;
      ALUOP_SLT: result_s = {31'd0, slt_s};
      default: begin
        result_s = 32'd0;
        err_s    = 1'b1;
      end
    endcase
  end

  assign alu_bus.result = result_s;
  assign alu_bus.zero   = (result_s == 32'd0);
  assign alu_bus.err    = err_s;

endmodule

// File: rtl/ucsbece154a_alu_arb.sv
// Two requesters share one ALU. One result register is held until the
// consumer takes it; a new request may be accepted in the same cycle the held
// result leaves, giving one result per cycle when the consumer keeps up.
module ucsbece154a_alu_arb
  import ucsbece154a_alu_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [2:0]  req0_alucontrol_i,
  input  logic [2:0]  req1_alucontrol_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_id_q, rsp_id_d;

  logic        grant0_s;
  logic        grant1_s;
  logic        slot_free_s;
  logic        accept_s;

  ucsbece154a_alu_arb_if alu_bus ();

  // Granted port's operands feed the single shared ALU
  assign alu_bus.a          = grant1_s ? req1_a_i          : req0_a_i;
  assign alu_bus.b          = grant1_s ? req1_b_i          : req0_b_i;
  assign alu_bus.alucontrol = grant1_s ? req1_alucontrol_i : req0_alucontrol_i;

  ucsbece154a_alu u_alu (
    .alu_bus (alu_bus.slave)
  );

  // Arbitration: a lone requester wins; on contention round-robin or port 0
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      if (RR_EN && !last_grant_q) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (req0_valid_i) begin
      grant0_s = 1'b1;
    end else if (req1_valid_i) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Slot is free when empty or when the held result leaves this cycle;
  // gating with reset_n keeps both ready outputs low during reset
  assign slot_free_s  = reset_n &&
                        ((state_q == ARB_IDLE) || ((state_q == ARB_HOLD) && rsp_ready_i));
  assign req0_ready_o = slot_free_s && grant0_s;
  assign req1_ready_o = slot_free_s && grant1_s;
  assign accept_s     = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);

  // Next-state and result-register loading
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      ARB_IDLE: begin
        if (accept_s) begin
          state_d = ARB_HOLD;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_HOLD: begin
        if (accept_s) begin
          state_d = ARB_HOLD;
        end else if (rsp_ready_i) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_HOLD;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (accept_s) begin
      last_grant_d = grant1_s;
      rsp_id_d     = grant1_s;
      if (op_supported(alu_bus.alucontrol)) begin
        rsp_result_d = alu_bus.result;
        rsp_zero_d   = alu_bus.zero;
        rsp_err_d    = 1'b0;
      end else begin
        rsp_result_d = 32'd0;
        rsp_zero_d   = 1'b1;
        rsp_err_d    = 1'b1;
      end
    end else begin
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
    end
  end

  // State and result registers; last_grant resets to 1 so port 0 wins first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid_o  = (state_q == ARB_HOLD);
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_id_o     = rsp_id_q;

endmodule

// File: tb/tb_ucsbece154a_alu_arb.sv
// Directed bench for the two-port ALU arbiter: round-robin and fixed-priority
// instances share stimulus; the ALU is also exercised on its own.
module tb_ucsbece154a_alu_arb;
  import ucsbece154a_alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [31:0] req0_a_i = 32'd0, req0_b_i = 32'd0, req1_a_i = 32'd0, req1_b_i = 32'd0;
  logic [2:0]  req0_alucontrol_i = 3'd0, req1_alucontrol_i = 3'd0;
  logic        rsp_ready_i = 1'b1;

  logic        req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_err_o;
  logic [31:0] rsp_result_o;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zero, fp_rsp_err;
  logic [31:0] fp_rsp_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ucsbece154a_alu_arb #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .req0_alucontrol_i(req0_alucontrol_i), .req1_alucontrol_i(req1_alucontrol_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o)
  );

  ucsbece154a_alu_arb #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_ready_o(fp_req0_ready), .req1_ready_o(fp_req1_ready),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .req0_alucontrol_i(req0_alucontrol_i), .req1_alucontrol_i(req1_alucontrol_i),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready_i), .rsp_id_o(fp_rsp_id),
    .rsp_result_o(fp_rsp_result), .rsp_zero_o(fp_rsp_zero), .rsp_err_o(fp_rsp_err)
  );

  ucsbece154a_alu_arb_if alu_bus ();
  ucsbece154a_alu u_alu_direct (.alu_bus(alu_bus.slave));

  task automatic apply_reset();
    reset_n = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0_valid_i = 1'b1; req0_alucontrol_i = ALUOP_ADD;
    @(posedge clk); #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", rsp_valid_o); end
    checks++; if (rsp_result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", rsp_result_o); end
    checks++; if ({rsp_zero_o, rsp_err_o, rsp_id_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {rsp_zero_o, rsp_err_o, rsp_id_o}); end
    checks++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready_o, req1_ready_o}); end
    req0_valid_i = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_a_i = 32'h7FFF_FFFF; req0_b_i = 32'd1; req0_alucontrol_i = ALUOP_ADD;
    #1;
    checks++; if (req0_ready_o !== 1'b1) begin failures++; $display("FAIL add_ready got=%0h exp=1", req0_ready_o); end
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL add_valid got=%0h exp=1", rsp_valid_o); end
    checks++; if (rsp_result_o !== 32'h8000_0000) begin failures++; $display("FAIL add_result got=%h exp=80000000", rsp_result_o); end
    checks++; if ({rsp_zero_o, rsp_err_o, rsp_id_o} !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", {rsp_zero_o, rsp_err_o, rsp_id_o}); end
    @(posedge clk); #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL add_drain got=%0h exp=0", rsp_valid_o); end
  endtask

  task automatic test_round_robin();
    logic exp_id;
    apply_reset();
    req0_valid_i = 1'b1; req0_a_i = 32'd10; req0_b_i = 32'd3; req0_alucontrol_i = ALUOP_ADD;
    req1_valid_i = 1'b1; req1_a_i = 32'd10; req1_b_i = 32'd3; req1_alucontrol_i = ALUOP_SUB;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      #1;
      checks++; if ({req0_ready_o, req1_ready_o} !== {~exp_id, exp_id}) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, {req0_ready_o, req1_ready_o}, {~exp_id, exp_id}); end
      @(posedge clk); #1;
      checks++; if ({rsp_valid_o, rsp_id_o} !== {1'b1, exp_id}) begin failures++; $display("FAIL rr_id[%0d] got=%b exp=%b", i, {rsp_valid_o, rsp_id_o}, {1'b1, exp_id}); end
      checks++; if (rsp_result_o !== (exp_id ? 32'd7 : 32'd13)) begin failures++; $display("FAIL rr_result[%0d] got=%0d exp=%0d", i, rsp_result_o, exp_id ? 7 : 13); end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rr_drain got=%0h exp=0", rsp_valid_o); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_a_i = 32'd5; req0_b_i = 32'd5; req0_alucontrol_i = ALUOP_SUB;
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_zero_o, rsp_id_o} !== 3'b110 || rsp_result_o !== 32'd0) begin failures++; $display("FAIL bp_load got=%b/%h exp=110/0", {rsp_valid_o, rsp_zero_o, rsp_id_o}, rsp_result_o); end
    req1_valid_i = 1'b1; req1_a_i = 32'h0000_000F; req1_b_i = 32'h0000_0003; req1_alucontrol_i = ALUOP_AND;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {req0_ready_o, req1_ready_o}); end
      @(posedge clk); #1;
      checks++; if ({rsp_valid_o, rsp_zero_o, rsp_id_o} !== 3'b110 || rsp_result_o !== 32'd0) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=110/0", i, {rsp_valid_o, rsp_zero_o, rsp_id_o}, rsp_result_o); end
    end
    rsp_ready_i = 1'b1;
    #1;
    checks++; if (req1_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0h exp=1", req1_ready_o); end
    @(posedge clk); #1;
    req1_valid_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_zero_o, rsp_id_o} !== 3'b101 || rsp_result_o !== 32'd3) begin failures++; $display("FAIL bp_next got=%b/%h exp=101/3", {rsp_valid_o, rsp_zero_o, rsp_id_o}, rsp_result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_slt_err();
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_a_i = 32'hFFFF_FFFF; req0_b_i = 32'd1; req0_alucontrol_i = ALUOP_SLT;
    @(posedge clk); #1;
    checks++; if (rsp_result_o !== 32'd1 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL slt_neg got=%h/%0h exp=1/0", rsp_result_o, rsp_err_o); end
    req0_alucontrol_i = 3'b111;
    @(posedge clk); #1;
    checks++; if ({rsp_err_o, rsp_zero_o} !== 2'b11 || rsp_result_o !== 32'd0) begin failures++; $display("FAIL bad_op got=%b/%h exp=11/0", {rsp_err_o, rsp_zero_o}, rsp_result_o); end
    req0_a_i = 32'h0000_00F0; req0_b_i = 32'h0000_000F; req0_alucontrol_i = ALUOP_OR;
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    checks++; if ({rsp_err_o, rsp_zero_o} !== 2'b00 || rsp_result_o !== 32'hFF) begin failures++; $display("FAIL or_op got=%b/%h exp=00/ff", {rsp_err_o, rsp_zero_o}, rsp_result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_hold();
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_a_i = 32'd1; req0_b_i = 32'd2; req0_alucontrol_i = ALUOP_ADD;
    @(posedge clk); #1;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd3) begin failures++; $display("FAIL mid_load got=%0h/%h exp=1/3", rsp_valid_o, rsp_result_o); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || rsp_result_o !== 32'd0) begin failures++; $display("FAIL mid_reset got=%0h/%h exp=0/0", rsp_valid_o, rsp_result_o); end
    checks++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin failures++; $display("FAIL mid_ready got=%b exp=00", {req0_ready_o, req1_ready_o}); end
    @(negedge clk);
    reset_n = 1'b1; rsp_ready_i = 1'b1;
    req1_valid_i = 1'b1; req1_a_i = 32'd9; req1_b_i = 32'd4; req1_alucontrol_i = ALUOP_SUB;
    #1;
    checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin failures++; $display("FAIL post_reset_ready got=%b exp=10", {req0_ready_o, req1_ready_o}); end
    @(posedge clk); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_id_o} !== 2'b10 || rsp_result_o !== 32'd3) begin failures++; $display("FAIL post_reset_grant got=%b/%h exp=10/3", {rsp_valid_o, rsp_id_o}, rsp_result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    req0_valid_i = 1'b1; req0_a_i = 32'd10; req0_b_i = 32'd3; req0_alucontrol_i = ALUOP_ADD;
    req1_valid_i = 1'b1; req1_a_i = 32'd10; req1_b_i = 32'd3; req1_alucontrol_i = ALUOP_SUB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({fp_req0_ready, fp_req1_ready} !== 2'b10) begin failures++; $display("FAIL fp_ready[%0d] got=%b exp=10", i, {fp_req0_ready, fp_req1_ready}); end
      @(posedge clk); #1;
      checks++; if ({fp_rsp_valid, fp_rsp_id} !== 2'b10 || fp_rsp_result !== 32'd13) begin failures++; $display("FAIL fp_rsp[%0d] got=%b/%0d exp=10/13", i, {fp_rsp_valid, fp_rsp_id}, fp_rsp_result); end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_direct();
    logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5};
    logic [31:0] tb [6] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
    logic [2:0]  top [6] = '{ALUOP_ADD, ALUOP_SUB, ALUOP_SLT, ALUOP_SLT, ALUOP_SLT, 3'b100};
    logic [31:0] er [6] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd0};
    logic [1:0]  ef [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 6; i++) begin
      alu_bus.a = ta[i]; alu_bus.b = tb[i]; alu_bus.alucontrol = top[i];
      #1;
      checks++; if (alu_bus.result !== er[i] || {alu_bus.zero, alu_bus.err} !== ef[i]) begin failures++; $display("FAIL alu_direct[%0d] got=%h/%b exp=%h/%b", i, alu_bus.result, {alu_bus.zero, alu_bus.err}, er[i], ef[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_backpressure();
    test_slt_err();
    test_reset_mid_hold();
    test_fixed_priority();
    test_alu_direct();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_alu_arb.md
UCSBECE154A_ALU_ARB -- requirements
Module: ucsbece154a_alu_arb

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 winning.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. The ports SHALL be, one per line, as listed in REQ-003 to REQ-014.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid_i, req1_valid_i  input  1 each  operation request.
REQ-006 req0_ready_o, req1_ready_o  output  1 each  request accepted this cycle.
REQ-007 req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  32 each  operands.
REQ-008 req0_alucontrol_i, req1_alucontrol_i  input  3 each  ALU op (and/or/add/sub/slt codes).
REQ-009 rsp_valid_o  output  1  result held.
REQ-010 rsp_ready_i  input  1  consumer takes the result.
REQ-011 rsp_id_o  output  1  requester index of the result.
REQ-012 rsp_result_o  output  32  registered ALU result.
REQ-013 rsp_zero_o  output  1  registered zero flag.
REQ-014 rsp_err_o  output  1  unsupported op code.

Function
REQ-015 The block SHALL share one ALU instance between the two requesters, with at most one result outstanding.
REQ-016 The FSM SHALL have two states: IDLE (no result held) and HOLD (rsp_valid_o=1).
REQ-017 The slot SHALL be free when state==IDLE, or when state==HOLD and rsp_ready_i==1.
REQ-018 Arbitration SHALL follow these rules:
- Grant is computed combinationally among the valid requesters.
- If both are valid and RR_EN=1, grant goes to the port not equal to last_grant.
- If RR_EN=0, port 0 wins.
- A single valid port always wins.
REQ-019 reqN_ready_o SHALL equal slot_free AND grantN. At most one ready_o SHALL be high per cycle. ready_o SHALL NOT depend on the other port's ready_o.
REQ-020 A transfer SHALL occur on a rising edge with reqN_valid_i AND reqN_ready_o. The ALU output SHALL be registered into the following registers:
- rsp_result_o
- rsp_zero_o
- rsp_err_o
- rsp_id_o=N
REQ-021 A transfer SHALL also set rsp_valid_o=1 and update last_grant. Latency SHALL be 1 cycle from accept to rsp_valid_o.
REQ-022 In HOLD with rsp_ready_i=0, all rsp_* outputs SHALL stay stable and both ready_o SHALL be 0.
REQ-023 In HOLD with rsp_ready_i=1:
- With a new transfer in the same cycle, the state SHALL stay HOLD with the new data loaded (back-to-back, throughput 1/cycle).
- Without one, the state SHALL go to IDLE and rsp_valid_o SHALL drop to 0.
REQ-024 A requester SHALL hold valid and operands stable until accepted. The block SHALL NOT require valid to be deasserted after acceptance.
REQ-025 For an op code outside {and, or, add, sub, slt}, the block SHALL register rsp_err_o=1, rsp_result_o=0 and rsp_zero_o=1 instead of the ALU value.
REQ-026 Add and sub SHALL wrap modulo 2^32. slt SHALL be a signed compare, with the result in bit 0 and zeros elsewhere.
REQ-027 While valid stays high, a requester SHALL be granted within 2 transfers; this is the no-starvation rule.

Reset
REQ-028 Asserting reset_n=0 at any time, including mid-HOLD, SHALL immediately force all of the following:
- state=IDLE
- rsp_valid_o=0
- rsp_result_o=0
- rsp_zero_o=0
- rsp_err_o=0
- rsp_id_o=0
- last_grant=1, so port 0 wins the first contention
REQ-029 While reset_n=0, both ready_o SHALL be 0. A result pending at reset SHALL be discarded.
REQ-030 Deassertion of reset_n SHALL be synchronised externally. The first accept SHALL be possible on the first rising edge after deassertion.

Structure
REQ-031 The shared defines header SHALL hold the ALUcontrol op-code constants and the state encodings ARB_IDLE and ARB_HOLD.
REQ-032 The block SHALL instantiate exactly one ucsbece154a_alu sub-module, fed by the granted port's operands through a 2:1 mux.
REQ-033 The block SHALL contain no other adders or comparators.

Verification
REQ-034 Port 0 only, add 0x7FFFFFFF+1, rsp_ready_i=1 -> next cycle rsp_valid_o=1, result 0x80000000, zero 0, id 0.
REQ-035 Both ports valid for 4 cycles with RR_EN=1 and rsp_ready_i=1 -> grants 0,1,0,1, one result per cycle.
REQ-036 Backpressure: rsp_ready_i=0 for 3 cycles after a sub 5-5 -> result 0, zero 1 held stable, both ready_o=0. Then rsp_ready_i=1 -> a new request is accepted in the same cycle.
REQ-037 slt with a=0xFFFFFFFF, b=1 -> result 1. Op code 3'b111 -> err 1, result 0, zero 1.
REQ-038 reset_n pulsed low mid-HOLD, between clock edges -> rsp_valid_o=0 immediately. After release, a contention goes to port 0.
REQ-039 RR_EN=0 with both valid for 3 cycles -> port 0 granted every cycle and req1_ready_o stays 0.
